router_pkt_tx: RTL and testbench

Packet source for the router input port. It accepts a packet request (destination address and payload length), buffers the payload from an upstream byte stream, and then drives the router input bus. The packet format is a header byte, then the payload bytes, then a parity byte, with stalls honoured on the router's `busy`. It sits between a traffic generator or host interface and the router top, and is the transmitting counterpart of the router's input register and parity logic.

---
 rtl/router_pkt_tx_if.sv | 27 ++
 rtl/router_pkt_tx.sv | 152 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// Bus bundle between a packet source and the router input port.
// The master modport is the transmitter; the slave modport is its environment.
interface router_pkt_tx_if;
  logic        start;
  logic [1:0]  dest_addr;
  logic [5:0]  pay_len;
  logic        start_ready;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic        busy;
  logic [7:0]  pkt_data;
  logic        pkt_valid;
  logic        tx_done;
  logic        cfg_err;
  logic [15:0] pkt_count;

  modport master (
    input  start, dest_addr, pay_len, src_data, src_valid, busy,
    output start_ready, src_ready, pkt_data, pkt_valid, tx_done, cfg_err, pkt_count
  );

  modport slave (
    output start, dest_addr, pay_len, src_data, src_valid, busy,
    input  start_ready, src_ready, pkt_data, pkt_valid, tx_done, cfg_err, pkt_count
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a whole payload, then sends header, payload
// and parity on the router input bus, honouring busy stalls.
module router_pkt_tx #(
  parameter int GAP_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  router_pkt_tx_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  wr_q, wr_d;
  logic [5:0]  rd_q, rd_d;
  logic [7:0]  par_q, par_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  pkt_data_q, pkt_data_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic        tx_done_q, tx_done_d;
  logic        cfg_err_q, cfg_err_d;
  logic [15:0] pkt_count_q;
  logic        wr_en;
  logic [7:0]  mem [64];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    par_d       = par_q;
    gap_d       = gap_q;
    tx_done_d   = 1'b0;
    cfg_err_d   = 1'b0;
    wr_en       = 1'b0;
    pkt_data_d  = 8'h00;
    pkt_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.dest_addr == 2'd3 || bus.pay_len == 6'd0) begin
            cfg_err_d = 1'b1;
          end else begin
            addr_d  = bus.dest_addr;
            len_d   = bus.pay_len;
            par_d   = {bus.pay_len, bus.dest_addr};
            wr_d    = 6'd0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (bus.src_valid) begin
          wr_en = 1'b1;
          par_d = par_q ^ bus.src_data;
          wr_d  = wr_q + 6'd1;
          if (wr_q == len_q - 6'd1) state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        if (!bus.busy) begin
          rd_d    = 6'd0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!bus.busy) begin
          if (rd_q == len_q - 6'd1) state_d = S_PARITY;
          else                      rd_d    = rd_q + 6'd1;
        end
      end
      S_PARITY: begin
        if (!bus.busy) begin
          tx_done_d = 1'b1;
          gap_d     = 4'(GAP_CYCLES - 1);
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus byte is decoded from the next state so the output register stays Moore.
    case (state_d)
      S_HEADER: begin
        pkt_data_d  = {len_d, addr_d};
        pkt_valid_d = 1'b1;
      end
      S_PAYLOAD: begin
        pkt_data_d  = mem[rd_d];
        pkt_valid_d = 1'b1;
      end
      S_PARITY: pkt_data_d = par_d;
      default:  pkt_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= 2'd0;
      len_q       <= 6'd0;
      wr_q        <= 6'd0;
      rd_q        <= 6'd0;
      par_q       <= 8'h00;
      gap_q       <= 4'd0;
      pkt_data_q  <= 8'h00;
      pkt_valid_q <= 1'b0;
      tx_done_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      pkt_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      par_q       <= par_d;
      gap_q       <= gap_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      tx_done_q   <= tx_done_d;
      cfg_err_q   <= cfg_err_d;
      if (tx_done_d) pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

  // NOTE: the payload buffer has no reset; contents are always written before being read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= bus.src_data;
  end

  assign bus.start_ready = (state_q == S_IDLE);
  assign bus.src_ready   = (state_q == S_LOAD);
  assign bus.pkt_data    = pkt_data_q;
  assign bus.pkt_valid   = pkt_valid_q;
  assign bus.tx_done     = tx_done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: expected bus bytes are queued when a
// request is driven and popped as the router consumes each byte.
module tb_router_pkt_tx;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_pkt_tx_if bus ();
  router_pkt_tx #(.GAP_CYCLES(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] pay [64];
  int n_checks = 0, n_pass = 0, cyc = 0;
  int n_tx = 0, n_cfg = 0, n_srcrdy = 0, n_valid = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: a byte is consumed when it is active on the bus and busy is low.
  logic       in_pkt = 1'b0, prev_hold = 1'b0, prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  initial forever begin
    logic  active;
    beat_t exp_b;
    @(negedge clk);
    if (rst) begin
      sb.delete();
      in_pkt    = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (bus.tx_done)   n_tx++;
      if (bus.cfg_err)   n_cfg++;
      if (bus.src_ready) n_srcrdy++;
      if (bus.pkt_valid) n_valid++;
      if (prev_hold) begin
        check("hold_data", bus.pkt_data, prev_data);
        check("hold_valid", bus.pkt_valid, prev_valid);
      end
      active     = bus.pkt_valid || in_pkt;
      prev_hold  = active && bus.busy;
      prev_data  = bus.pkt_data;
      prev_valid = bus.pkt_valid;
      if (active && !bus.busy) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_b = sb.pop_front();
          check("bus_data", bus.pkt_data, exp_b.data);
          check("bus_valid", bus.pkt_valid, exp_b.valid);
        end
        in_pkt = bus.pkt_valid;
      end
    end
  end

  task automatic push_beat(input logic [7:0] d, input logic v);
    beat_t b;
    b.data  = d;
    b.valid = v;
    sb.push_back(b);
  endtask

  task automatic wait_ready(output int waited);
    int budget = 300;
    waited = 0;
    while (!bus.start_ready && budget > 0) begin
      @(posedge clk); #1;
      waited++;
      budget--;
    end
    check("start_ready_wait", bus.start_ready, 1);
  endtask

  task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input bit gaps, output int acc);
    int idx, budget, w;
    logic [7:0] par;
    bit tog, fire;
    wait_ready(w);
    bus.start = 1'b1; bus.dest_addr = a; bus.pay_len = l;
    @(posedge clk); #1;
    acc = cyc;
    bus.start = 1'b0;
    par = {l, a};
    push_beat({l, a}, 1'b1);
    for (int i = 0; i < int'(l); i++) begin
      push_beat(pay[i], 1'b1);
      par = par ^ pay[i];
    end
    push_beat(par, 1'b0);
    idx = 0; budget = 1000; tog = 1'b0;
    while (idx < int'(l) && budget > 0) begin
      bus.src_valid = gaps ? tog : 1'b1;
      bus.src_data  = pay[idx];
      tog = !tog;
      @(negedge clk);
      fire = bus.src_valid && bus.src_ready;
      @(posedge clk); #1;
      if (fire) idx++;
      budget--;
    end
    bus.src_valid = 1'b0;
    bus.src_data  = $urandom_range(255);
    check("load_done", idx, int'(l));
  endtask

  task automatic wait_tx(output int tc);
    int budget = 500;
    while (!bus.tx_done && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("tx_done_seen", bus.tx_done, 1);
    tc = cyc;
  endtask

  task automatic wait_byte(input logic [7:0] d);
    int budget = 300;
    while (!(bus.pkt_valid && bus.pkt_data == d) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("byte_seen", bus.pkt_data, d);
  endtask

  initial begin
    int acc, tc, w, tx0, c0, s0, v0;
    logic [1:0] rej_a [2];
    logic [5:0] rej_l [2];
    bus.start = 0; bus.dest_addr = 0; bus.pay_len = 0;
    bus.src_data = 0; bus.src_valid = 0; bus.busy = 0;

    // Reset with random inputs, including start, for two edges.
    rst = 1'b1;
    repeat (2) begin
      bus.start     = $urandom_range(1);
      bus.dest_addr = $urandom_range(3);
      bus.pay_len   = $urandom_range(63);
      bus.src_data  = $urandom_range(255);
      bus.src_valid = $urandom_range(1);
      bus.busy      = $urandom_range(1);
      @(posedge clk); #1;
    end
    check("rst_pkt_data", bus.pkt_data, 0);
    check("rst_pkt_valid", bus.pkt_valid, 0);
    check("rst_tx_done", bus.tx_done, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_pkt_count", bus.pkt_count, 0);
    check("rst_src_ready", bus.src_ready, 0);
    check("rst_start_ready", bus.start_ready, 1);
    rst = 1'b0;
    bus.start = 0; bus.src_valid = 0; bus.busy = 0;
    @(posedge clk); #1;

    // Basic packet.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    tx0 = n_tx;
    send_pkt(2'd1, 6'd3, 1'b0, acc);
    wait_tx(tc);
    check("basic_latency", tc - acc, 8);
    check("basic_count", bus.pkt_count, 1);
    wait_ready(w);
    check("basic_gap", w, GAP);
    check("basic_tx_once", n_tx - tx0, 1);
    check("basic_sb_empty", sb.size(), 0);

    // Same packet with a 3-cycle stall on 0x22.
    send_pkt(2'd1, 6'd3, 1'b0, acc);
    wait_byte(8'h22);
    bus.busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.busy = 1'b0;
    wait_tx(tc);
    check("stall_latency", tc - acc, 11);
    check("stall_count", bus.pkt_count, 2);
    wait_ready(w);
    check("stall_sb_empty", sb.size(), 0);

    // Illegal requests.
    rej_a[0] = 2'd3; rej_l[0] = 6'd5;
    rej_a[1] = 2'd0; rej_l[1] = 6'd0;
    for (int k = 0; k < 2; k++) begin
      wait_ready(w);
      c0 = n_cfg; s0 = n_srcrdy; v0 = n_valid;
      bus.start = 1'b1; bus.dest_addr = rej_a[k]; bus.pay_len = rej_l[k];
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("rej_cfg_err", bus.cfg_err, 1);
      check("rej_tx_done", bus.tx_done, 0);
      check("rej_idle", bus.start_ready, 1);
      @(posedge clk); #1;
      check("rej_cfg_pulse", bus.cfg_err, 0);
      repeat (4) @(posedge clk);
      #1;
      check("rej_cfg_once", n_cfg - c0, 1);
      check("rej_no_src_ready", n_srcrdy - s0, 0);
      check("rej_no_valid", n_valid - v0, 0);
    end

    // Maximum length with gaps in src_valid.
    for (int i = 0; i < 63; i++) pay[i] = 8'($urandom_range(255));
    v0 = n_valid;
    send_pkt(2'd2, 6'd63, 1'b1, acc);
    wait_tx(tc);
    check("max_valid_beats", n_valid - v0, 64);
    check("max_count", bus.pkt_count, 3);
    wait_ready(w);
    check("max_sb_empty", sb.size(), 0);

    // Reset during the second payload byte of a 5-byte packet.
    for (int i = 0; i < 5; i++) pay[i] = 8'(8'h31 + i);
    send_pkt(2'd1, 6'd5, 1'b0, acc);
    wait_byte(8'h32);
    rst = 1'b1;
    tx0 = n_tx;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", bus.pkt_valid, 0);
    check("abort_idle", bus.start_ready, 1);
    check("abort_count", bus.pkt_count, 0);
    check("abort_tx_done", bus.tx_done, 0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_tx", n_tx - tx0, 0);

    // One-byte packet after the abort: 0x04, 0xA5, 0xA1.
    pay[0] = 8'hA5;
    send_pkt(2'd0, 6'd1, 1'b0, acc);
    wait_tx(tc);
    check("one_latency", tc - acc, 4);
    check("one_count", bus.pkt_count, 1);
    wait_ready(w);
    check("one_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
